uart_tx_fifo: RTL and testbench

- Byte buffer and launch sequencer that sits directly upstream of uart_core's transmit side.
- Accepts bytes from a producer over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Drives uart_core's tx_start/tx_data one byte at a time, pacing launches on tx_busy.
- Lets software/producer logic burst data without waiting for each serial frame to complete.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_byte_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 98 +++++++++
 tb/tb_uart_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit buffer.
package uart_pkg;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned DEPTH_DEF     = 16;
    localparam int unsigned BUSY_WAIT_DEF = 4;

    // Launch sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with push/pop/flush; DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
module uart_byte_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_W-1:0]            din,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head_c,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full_c,
    output logic                         empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    // Flush wins over both ports so nothing moves in the clearing cycle
    assign do_push = push && !full_c && !flush;
    assign do_pop  = pop && !empty_c && !flush;
    assign head_c  = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer and launch sequencer feeding uart_core's tx side.
// Bytes are accepted on a valid/ready port, queued, and launched one at a time
// with a single-cycle tx_start, paced on tx_busy. A launch that never sees
// tx_busy rise within BUSY_WAIT cycles sets the sticky launch_lost flag.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BUSY_WAIT = BUSY_WAIT_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         s_valid,
    input  logic [DATA_W-1:0]            s_data,
    output logic                         s_ready,
    output logic                         tx_start,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         launch_lost
);

    localparam int unsigned WW = $clog2(BUSY_WAIT + 1);

    tx_state_e         state;
    logic [WW-1:0]     wait_cnt;
    logic [DATA_W-1:0] head_c;
    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;

    // Ready depends on flush directly so a flushing cycle never accepts data
    assign s_ready = !full_c && !flush;
    assign push_c  = s_valid && s_ready;
    assign pop_c   = (state == IDLE) && !empty_c && !tx_busy && !flush;

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push_c),
        .din     (s_data),
        .pop     (pop_c),
        .head_c  (head_c),
        .count   (count),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Launch FSM: pop into tx_data, pulse tx_start, then track the frame via tx_busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            wait_cnt    <= '0;
            launch_lost <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        tx_data  <= head_c;
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == WW'(BUSY_WAIT - 1)) begin
                        launch_lost <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a small behavioural transmitter stands in for
// uart_core (busy rises the cycle after tx_start and holds for FRAME cycles).
// Launched bytes are checked in order against a queue of expected bytes.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BUSY_WAIT = 4;
    localparam int          FRAME     = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [4:0] count;
    logic       launch_lost;

    logic       core_en;
    logic       hold_busy;
    logic       model_busy;
    int         model_cnt;
    logic       prev_start = 1'b0;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    assign tx_busy = (core_en & model_busy) | hold_busy;

    uart_tx_fifo #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .count       (count),
        .launch_lost (launch_lost)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter stand-in
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (core_en && tx_start && !model_busy) begin
            model_busy <= 1'b1;
            model_cnt  <= FRAME - 1;
        end else if (model_busy) begin
            if (model_cnt == 0) model_busy <= 1'b0;
            else                model_cnt  <= model_cnt - 1;
        end
    end

    // Monitor: every launch must carry the next expected byte
    always @(negedge clk) begin
        if (!reset && tx_start) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_launch", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                chk("launch_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            chk("launch_while_busy", 32'(tx_busy), 32'd0);
            chk("start_one_cycle", 32'(prev_start), 32'd0);
        end
        prev_start <= tx_start && !reset;
    end

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("push_timeout", 32'(d), 32'hFFFF_FFFF);
        end else begin
            exp_q.push_back(d);
            @(posedge clk);
        end
        #1 s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || count != 0 || tx_busy || tx_start) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        flush     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        core_en   = 1'b1;
        hold_busy = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_lost", 32'(launch_lost), 32'd0);

        // Single byte: launch one cycle after the count becomes 1
        push(8'hA5);
        chk("t1_no_early_start", 32'(tx_start), 32'd0);
        chk("t1_count_one", 32'(count), 32'd1);
        @(posedge clk); #1;
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        @(posedge clk); #1;
        chk("t1_start_low", 32'(tx_start), 32'd0);
        chk("t1_data_held", 32'(tx_data), 32'hA5);
        drain();
        chk("t1_count_zero", 32'(count), 32'd0);

        // Burst to full while the core is held busy
        hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        chk("t2_count_full", 32'(count), 32'd16);
        chk("t2_ready_low", 32'(s_ready), 32'd0);

        // Full plus pop: 0x77 waits until the first launch frees a slot
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_hold_count", 32'(count), 32'd16);
        chk("t3_hold_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        hold_busy = 1'b0;
        @(posedge clk); #1;
        chk("t3_pop_count", 32'(count), 32'd15);
        chk("t3_pop_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        exp_q.push_back(8'h77);
        s_valid = 1'b0;
        chk("t3_refill_count", 32'(count), 32'd16);
        drain();

        // Simultaneous push and pop leaves count unchanged
        hold_busy = 1'b1;
        push(8'hAA);
        push(8'hBB);
        chk("t3b_count_two", 32'(count), 32'd2);
        @(negedge clk);
        hold_busy = 1'b0;
        s_valid   = 1'b1;
        s_data    = 8'hCC;
        @(posedge clk); #1;
        s_valid = 1'b0;
        exp_q.push_back(8'hCC);
        chk("t3b_simul_count", 32'(count), 32'd2);
        drain();

        // Pointer wrap: 40 bytes in groups of 10
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 10; i++) push(8'(g * 10 + i));
            drain();
        end
        chk("t4_count_zero", 32'(count), 32'd0);

        // Flush during the first frame drops the queued bytes only
        push(8'h11);
        push(8'h22);
        push(8'h33);
        n = 0;
        while (!tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_busy_seen", 32'(tx_busy), 32'd1);
        @(negedge clk);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h99;
        #1;
        chk("t5_flush_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        flush   = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        chk("t5_flush_count", 32'(count), 32'd0);
        push(8'h44);
        drain();

        // Dead core: launch_lost exactly BUSY_WAIT cycles after WAIT_BUSY entry
        core_en = 1'b0;
        push(8'h5A);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_lost_early", 32'(launch_lost), 32'd0);
        @(posedge clk); #1;
        chk("t6_lost_set", 32'(launch_lost), 32'd1);
        core_en = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h5B);
        drain();
        chk("t6_lost_sticky", 32'(launch_lost), 32'd1);

        // Reset mid-launch clears everything at once
        push(8'hC1);
        push(8'hC2);
        chk("t7_pre_start", 32'(tx_start), 32'd1);
        reset = 1'b1;
        #1;
        chk("t7_rst_start", 32'(tx_start), 32'd0);
        chk("t7_rst_count", 32'(count), 32'd0);
        chk("t7_rst_lost", 32'(launch_lost), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t7_ready", 32'(s_ready), 32'd1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
